prbs_checker: RTL and testbench

Serial pseudo-random bit-sequence checker, the receive-side counterpart of the team's 4-bit LFSR pattern generator (polynomial x^4 + x^3 + 1).
- Consumes the generator's bit-0 stream, one bit per valid cycle.
- Self-synchronises to the stream, declares lock, then counts bit errors against a free-running local reference.
- Sits at the far end of a test link and drives the BER/status registers.

---
 rtl/prbs_pkg.sv | 17 +
 rtl/prbs_sat_cnt.sv | 29 ++
 rtl/prbs_checker.sv | 184 ++++++++++++++++++
 tb/tb_prbs_checker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared definitions for the x^4 + x^3 + 1 PRBS generator/checker pair.
//   state_t      : checker FSM states
//   PRBS_POLY_W  : default LFSR length (history register width)
//   PRBS_TAPS    : default feedback mask, predicted bit = ^(hist & TAPS)
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int         PRBS_POLY_W = 4;
    localparam logic [3:0] PRBS_TAPS   = 4'b1100;

endpackage

// File: rtl/prbs_sat_cnt.sv
// prbs_sat_cnt
// Saturating up-counter used for the error and compared-bit counters.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   clear  in   synchronous clear, wins over inc
//   inc    in   add one this cycle (ignored once all-ones)
//   cnt    out  WIDTH-bit count, sticks at all-ones
module prbs_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side checker for the 4-bit LFSR pattern generator. Self-synchronises
// to the serial stream (SEARCH -> VERIFY -> LOCKED), then counts bit errors
// against a free-running local reference.
// Optional feature macro: PRBS_CHK_BITCNT_EN adds the bit_cnt output.
// Ports:
//   clk        in   rising-edge clock
//   async_rst  in   asynchronous active-high reset
//   sync_rst   in   synchronous active-high clear, dominates din_vld
//   din_vld    in   din is valid this cycle
//   din        in   received serial bit
//   locked     out  checker is in LOCKED (registered)
//   err_pulse  out  one-cycle pulse per error detected while LOCKED
//   err_cnt    out  saturating error count, held across lock loss
//   bit_cnt    out  (macro only) saturating count of bits compared while LOCKED
//
// state  | meaning
// SEARCH | filling history from the line, waiting for a nonzero fill
// VERIFY | self-synchronised prediction, counting consecutive matches
// LOCKED | free-running reference, counting errors
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int                POLY_W      = PRBS_POLY_W,
    parameter logic [POLY_W-1:0] TAPS        = PRBS_TAPS,
    parameter int                LOCK_CNT    = 8,
    parameter int                LOSS_THRESH = 3,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             sync_rst,
    input  logic             din_vld,
    input  logic             din,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] bit_cnt
`endif
);

    localparam int FILL_W = $clog2(POLY_W + 1);
    localparam int OK_W   = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(POLY_W);
    localparam logic [OK_W-1:0]   OK_MAX   = OK_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(LOSS_THRESH);

    state_t              state, state_n;
    logic [POLY_W-1:0]   hist, hist_n;
    logic [FILL_W-1:0]   fill_cnt, fill_n;
    logic [OK_W-1:0]     ok_cnt, ok_n;
    logic [BAD_W-1:0]    bad_cnt, bad_n;
    logic                pulse_n;
    logic                err_inc;

    logic                pred;
    logic                mismatch;
    logic [POLY_W-1:0]   shift_din;
    logic [POLY_W-1:0]   shift_pred;

    assign pred       = ^(hist & TAPS);
    assign mismatch   = din ^ pred;
    assign shift_din  = {hist[POLY_W-2:0], din};
    assign shift_pred = {hist[POLY_W-2:0], pred};

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state     <= SEARCH;
            hist      <= '0;
            fill_cnt  <= '0;
            ok_cnt    <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else if (sync_rst) begin
            state     <= SEARCH;
            hist      <= '0;
            fill_cnt  <= '0;
            ok_cnt    <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_n;
            ok_cnt    <= ok_n;
            bad_cnt   <= bad_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        hist_n  = hist;
        fill_n  = fill_cnt;
        ok_n    = ok_cnt;
        bad_n   = bad_cnt;
        pulse_n = 1'b0;
        err_inc = 1'b0;
        if (din_vld) begin
            case (state)
                SEARCH: begin
                    hist_n = shift_din;
                    if (fill_cnt != FILL_MAX) begin
                        fill_n = fill_cnt + 1'b1;
                    end
                    // An all-zero history is the LFSR lock-up state: keep waiting.
                    if ((fill_n == FILL_MAX) && (shift_din != '0)) begin
                        state_n = VERIFY;
                        ok_n    = '0;
                    end
                end
                VERIFY: begin
                    // Reload from the line so a bad fill washes out on its own.
                    hist_n = shift_din;
                    if (shift_din == '0) begin
                        state_n = SEARCH;
                        fill_n  = '0;
                        ok_n    = '0;
                    end else if (!mismatch) begin
                        ok_n = ok_cnt + 1'b1;
                        if (ok_n == OK_MAX) begin
                            state_n = LOCKED;
                            bad_n   = '0;
                        end
                    end else begin
                        ok_n = '0;
                    end
                end
                LOCKED: begin
                    // Reference free-runs: a line error never enters the history.
                    hist_n = shift_pred;
                    if (mismatch) begin
                        pulse_n = 1'b1;
                        err_inc = 1'b1;
                        bad_n   = bad_cnt + 1'b1;
                        if (bad_n == BAD_MAX) begin
                            state_n = SEARCH;
                            fill_n  = '0;
                            ok_n    = '0;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
                default: begin
                    state_n = SEARCH;
                    fill_n  = '0;
                    ok_n    = '0;
                    bad_n   = '0;
                end
            endcase
        end
    end

    prbs_sat_cnt #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (async_rst),
        .clear (sync_rst),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );

`ifdef PRBS_CHK_BITCNT_EN
    logic bit_inc;

    assign bit_inc = din_vld && (state == LOCKED);

    prbs_sat_cnt #(.WIDTH(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (async_rst),
        .clear (sync_rst),
        .inc   (bit_inc),
        .cnt   (bit_cnt)
    );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
// Directed vector table for prbs_checker plus hand-written reset sequences.
// Each table row drives sync_rst/din_vld/din for one cycle and gives the
// locked/err_pulse/err_cnt expected just after that clock edge.
module tb_prbs_checker;

    logic        clk;
    logic        async_rst;
    logic        sync_rst;
    logic        din_vld;
    logic        din;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] bit_cnt;
`endif

    prbs_checker dut (
        .clk       (clk),
        .async_rst (async_rst),
        .sync_rst  (sync_rst),
        .din_vld   (din_vld),
        .din       (din),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          srst;
        bit          vld;
        bit          d;
        bit          exp_locked;
        bit          exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t  vecs[$];
    bit    ref_bits[15] = '{1,0,0,0,1,0,0,1,1,0,1,0,1,1,1};
    int    pos;
    string phase;
    int    tests;
    int    fails;

    task automatic add(bit srst, bit vld, bit d, bit l, bit p, int c);
        vec_t v;
        v.tag        = phase;
        v.srst       = srst;
        v.vld        = vld;
        v.d          = d;
        v.exp_locked = l;
        v.exp_pulse  = p;
        v.exp_cnt    = 16'(c);
        vecs.push_back(v);
    endtask

    // Next reference bit (optionally inverted), advancing the stream position.
    task automatic add_ref(bit inv, bit l, bit p, int c);
        add(1'b0, 1'b1, ref_bits[pos % 15] ^ inv, l, p, c);
        pos++;
    endtask

    task automatic check(string name, bit l, bit p, logic [15:0] c);
        tests++;
        if (locked !== l || err_pulse !== p || err_cnt !== c) begin
            fails++;
            $display("FAIL %s: got locked=%0b err_pulse=%0b err_cnt=%0d, want locked=%0b err_pulse=%0b err_cnt=%0d",
                     name, locked, err_pulse, err_cnt, l, p, c);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        pos       = 0;
        async_rst = 1'b1;
        sync_rst  = 1'b0;
        din_vld   = 1'b0;
        din       = 1'b0;

        // 1: clean stream, lock on the 12th valid bit, no errors over 150 bits
        phase = "clean_lock";
        for (int i = 0; i < 150; i++) add_ref(1'b0, i >= 11, 1'b0, 0);
        // 2: single inverted bit while locked
        phase = "single_err";
        add_ref(1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 20; i++) add_ref(1'b0, 1'b1, 1'b0, 1);
        // 3: three consecutive errors drop lock, then relock 12 bits later
        phase = "burst_loss";
        add_ref(1'b1, 1'b1, 1'b1, 2);
        add_ref(1'b1, 1'b1, 1'b1, 3);
        add_ref(1'b1, 1'b0, 1'b1, 4);
        phase = "relock";
        for (int i = 0; i < 12; i++) add_ref(1'b0, i >= 11, 1'b0, 4);
        for (int i = 0; i < 5; i++) add_ref(1'b0, 1'b1, 1'b0, 4);
        // 6b: sync_rst with a valid bit; the bit must not count toward the fill
        phase = "sync_rst";
        add(1'b1, 1'b1, ref_bits[pos % 15], 1'b0, 1'b0, 0);
        pos++;
        phase = "post_sync_lock";
        for (int i = 0; i < 12; i++) add_ref(1'b0, i >= 11, 1'b0, 0);
        // 4: all-zero stream never locks
        phase = "zero_stream";
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 50; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        // 5: valid every third cycle, idle cycles carry garbage din
        phase = "sparse_vld";
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 15; k++) begin
            add(1'b0, 1'b0, 1'b1, k >= 12, 1'b0, 0);
            add(1'b0, 1'b0, 1'b0, k >= 12, 1'b0, 0);
            add_ref(1'b0, k >= 11, 1'b0, 0);
        end
        phase = "sparse_err";
        add_ref(1'b1, 1'b1, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 4; i++) add_ref(1'b0, 1'b1, 1'b0, 1);
        add_ref(1'b1, 1'b1, 1'b1, 2);
        for (int i = 0; i < 3; i++) add_ref(1'b0, 1'b1, 1'b0, 2);

        #12;
        check("reset_state", 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        async_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            sync_rst = vecs[i].srst;
            din_vld  = vecs[i].vld;
            din      = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i),
                  vecs[i].exp_locked, vecs[i].exp_pulse, vecs[i].exp_cnt);
        end

        // 6a: locked with err_cnt=2, async_rst between edges clears at once
        @(negedge clk);
        sync_rst = 1'b0;
        din_vld  = 1'b0;
        din      = 1'b0;
        check("pre_async", 1'b1, 1'b0, 16'd2);
        #1;
        async_rst = 1'b1;
        #1;
        check("async_immediate", 1'b0, 1'b0, 16'd0);
        async_rst = 1'b0;
        @(posedge clk);
        #1;
        check("async_hold", 1'b0, 1'b0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
